// File: rtl/ramr_pkg.sv
// Shared definitions for the command-word reader (ramr) and its writer twin.
package ramr_pkg;

  typedef enum logic [7:0] {
    IDLE = 8'h00,
    READ = 8'h01,
    LAST = 8'h02,
    ERRS = 8'h03
  } state_t;

  localparam int unsigned NUM_BYTE_DEF = 12;
  localparam logic [15:0] TIMEOUT_DEF  = 16'd1000;

endpackage

// File: rtl/ramr_if.sv
// Parent handshake (fs/fd/err/data) plus byte-FIFO read port for ramr.
interface ramr_if #(
  parameter int unsigned NUM_BYTE = ramr_pkg::NUM_BYTE_DEF
) ();

  logic                  fs;
  logic                  fd;
  logic                  err;
  logic                  fifo_rxen;
  logic [7:0]            fifo_rxd;
  logic                  fifo_empty;
  logic [8*NUM_BYTE-1:0] data;

  modport master (
    output fs, fifo_rxd, fifo_empty,
    input  fd, err, fifo_rxen, data
  );

  modport slave (
    input  fs, fifo_rxd, fifo_empty,
    output fd, err, fifo_rxen, data
  );

endinterface

// File: rtl/ramr_tmo.sv
// Saturating idle timer: cleared by clr, otherwise counts up on inc and sticks at all-ones.
module ramr_tmo #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ramr.sv
// Byte-FIFO to command-word reader: pops NUM_BYTE bytes MSB-first into one word.
// Optional trailing XOR checksum check is built when RAMR_CHKSUM_EN is defined.
module ramr
  import ramr_pkg::*;
#(
  parameter int unsigned NUM_BYTE = NUM_BYTE_DEF,
  parameter logic [15:0] TIMEOUT  = TIMEOUT_DEF
) (
  input  logic   clk,
  input  logic   rst,
  ramr_if.slave  bus
);

  localparam int unsigned   W       = 8 * NUM_BYTE;
  localparam int unsigned   CW      = $clog2(NUM_BYTE + 1);
  localparam logic [CW-1:0] NB_C    = CW'(NUM_BYTE);
  localparam logic [CW-1:0] NB_LAST = CW'(NUM_BYTE - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] icnt;
  logic [CW-1:0] ccnt;
  logic          rd_vld;
  logic [W-1:0]  sreg;
  logic [W-1:0]  data_q;
  logic [W-1:0]  shifted;
  logic [15:0]   timer;
  logic          rxen;
  logic          cap_last;
  logic          timed_out;
  logic          chk_ok;

  assign shifted   = {sreg[W-9:0], bus.fifo_rxd};
  assign cap_last  = rd_vld && (ccnt == NB_LAST);
  // Once every pop is issued the timeout no longer applies; the last capture must land.
  assign timed_out = (timer >= TIMEOUT) && (icnt < NB_C);

`ifdef RAMR_CHKSUM_EN
  logic [7:0] xacc;

  assign chk_ok = ((xacc ^ bus.fifo_rxd) == 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      xacc <= '0;
    end else if ((state == IDLE) && bus.fs) begin
      xacc <= '0;
    end else if ((state == READ) && rd_vld) begin
      xacc <= xacc ^ bus.fifo_rxd;
    end
  end
`else
  assign chk_ok = 1'b1;
`endif

  ramr_tmo #(
    .W (16)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr ((state != READ) || rxen),
    .inc (state == READ),
    .cnt (timer)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.fs) state_nx = READ;
      READ: begin
        if (cap_last) begin
          state_nx = chk_ok ? LAST : ERRS;
        end else if (timed_out) begin
          state_nx = ERRS;
        end
      end
      LAST,
      ERRS: if (!bus.fs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rxen    = (state == READ) && !bus.fifo_empty && (icnt < NB_C);
    bus.fd  = (state == LAST) || (state == ERRS);
    bus.err = (state == ERRS);
  end

  assign bus.fifo_rxen = rxen;
  assign bus.data      = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      icnt   <= '0;
      ccnt   <= '0;
      rd_vld <= 1'b0;
      sreg   <= '0;
      data_q <= '0;
    end else begin
      rd_vld <= rxen;
      if (state == IDLE) begin
        if (bus.fs) begin
          icnt <= '0;
          ccnt <= '0;
          sreg <= '0;
        end
      end else if (state == READ) begin
        if (rxen) begin
          icnt <= icnt + 1'b1;
        end
        if (rd_vld) begin
          sreg <= shifted;
          ccnt <= ccnt + 1'b1;
        end
        if (cap_last && chk_ok) begin
          data_q <= shifted;
        end
      end
    end
  end

endmodule

// File: tb/tb_ramr.sv
// Self-checking bench for ramr: behavioural byte FIFO, vector table and corner-case sequences.
module tb_ramr;
  import ramr_pkg::*;

  typedef struct {
    logic [95:0] data;
    logic        err;
    int unsigned pops;
    int unsigned lat;
  } exp_t;

  typedef struct {
    int unsigned n;
    logic [7:0]  base;
    logic [95:0] data;
    logic        err;
    int unsigned lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ramr_if #(.NUM_BYTE(12)) bus ();

  ramr #(
    .NUM_BYTE (12),
    .TIMEOUT  (16'd1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: pop decision taken mid-cycle, dout and empty update on the edge.
  logic [7:0]  fq[$];
  logic        stall  = 1'b0;
  logic        do_pop = 1'b0;
  int unsigned pops   = 0;

  always @(negedge clk) do_pop = bus.fifo_rxen && !bus.fifo_empty;

  always @(posedge clk) begin
    if (do_pop && (fq.size() > 0)) begin
      bus.fifo_rxd <= fq.pop_front();
      pops         <= pops + 1;
    end
    bus.fifo_empty <= stall || (fq.size() == 0);
  end

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_bytes(input logic [7:0] base, input int unsigned n);
    @(negedge clk);
    for (int unsigned i = 0; i < n; i++) fq.push_back(base + 8'(i));
  endtask

  task automatic wait_pops(input int unsigned p0, input int unsigned n, input string tag);
    int unsigned cyc;
    cyc = 0;
    while (((pops - p0) < n) && (cyc < 500)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if ((pops - p0) < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_pop_wait: got %0d pops expected %0d", tag, pops - p0, n);
    end
  endtask

  task automatic run_txn(input string tag, input exp_t e);
    exp_t        got;
    int unsigned cyc;
    int unsigned p0;
    @(negedge clk);
    p0 = pops;
    sb.push_back(e);
    bus.fs = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.fd && (cyc < 2000));
    got = sb.pop_front();
    if (!bus.fd) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_fd: got fd=0 after %0d cycles expected fd=1", tag, cyc);
    end
    check({tag, "_data"}, bus.data, got.data);
    check({tag, "_err"}, 96'(bus.err), 96'(got.err));
    check({tag, "_pops"}, 96'(pops - p0), 96'(got.pops));
    if (got.lat != 0) check({tag, "_lat"}, 96'(cyc), 96'(got.lat));
    @(negedge clk);
    bus.fs = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_fd_drop"}, 96'(bus.fd), 96'd0);
  endtask

  vec_t tbl[5];

  initial begin
    exp_t        e;
    int unsigned p0;
    logic [7:0]  cs;

    tbl[0] = '{n: 12, base: 8'h01, data: 96'h0102030405060708090A0B0C, err: 1'b0, lat: 14};
    tbl[1] = '{n: 12, base: 8'hF4, data: 96'hF4F5F6F7F8F9FAFBFCFDFEFF, err: 1'b0, lat: 14};
    tbl[2] = '{n: 12, base: 8'h80, data: 96'h808182838485868788898A8B, err: 1'b0, lat: 14};
    tbl[3] = '{n: 7,  base: 8'h20, data: 96'h808182838485868788898A8B, err: 1'b1, lat: 1009};
    tbl[4] = '{n: 12, base: 8'h30, data: 96'h303132333435363738393A3B, err: 1'b0, lat: 14};

    bus.fs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fd", 96'(bus.fd), 96'd0);
    check("rst_err", 96'(bus.err), 96'd0);
    check("rst_rxen", 96'(bus.fifo_rxen), 96'd0);
    check("rst_data", bus.data, 96'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef RAMR_CHKSUM_EN
    cs = 8'h00;
    for (int unsigned i = 0; i < 11; i++) cs = cs ^ (8'h01 + 8'(i));
    push_bytes(8'h01, 11);
    fq.push_back(cs);
    e = '{data: {88'h0102030405060708090A0B, cs}, err: 1'b0, pops: 12, lat: 14};
    run_txn("chk_good", e);
    push_bytes(8'h01, 11);
    fq.push_back(cs ^ 8'h0B);
    e = '{data: {88'h0102030405060708090A0B, cs}, err: 1'b1, pops: 12, lat: 14};
    run_txn("chk_bad", e);
`else
    foreach (tbl[i]) begin
      push_bytes(tbl[i].base, tbl[i].n);
      e = '{data: tbl[i].data, err: tbl[i].err, pops: tbl[i].n, lat: tbl[i].lat};
      run_txn($sformatf("vec%0d", i), e);
    end

    // Deep FIFO: only one word's worth may be popped per request.
    push_bytes(8'h01, 20);
    e = '{data: 96'h0102030405060708090A0B0C, err: 1'b0, pops: 12, lat: 14};
    run_txn("deep1", e);
    check("deep_left", 96'(fq.size()), 96'd8);
    check("deep_empty", 96'(bus.fifo_empty), 96'd0);
    push_bytes(8'h15, 4);
    e = '{data: 96'h0D0E0F101112131415161718, err: 1'b0, pops: 12, lat: 0};
    run_txn("deep2", e);

    // Empty stall mid-word.
    push_bytes(8'h51, 12);
    p0 = pops;
    e = '{data: 96'h5152535455565758595A5B5C, err: 1'b0, pops: 12, lat: 0};
    fork
      run_txn("stall", e);
      begin
        wait_pops(p0, 5, "stall");
        stall = 1'b1;
        repeat (50) @(negedge clk);
        stall = 1'b0;
      end
    join

    // Reset in the middle of a word.
    push_bytes(8'h61, 12);
    @(negedge clk);
    p0 = pops;
    bus.fs = 1'b1;
    wait_pops(p0, 6, "rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_fd", 96'(bus.fd), 96'd0);
    check("rst_mid_data", bus.data, 96'd0);
    check("rst_mid_rxen", 96'(bus.fifo_rxen), 96'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.fs = 1'b0;
    fq.delete();
    push_bytes(8'h71, 12);
    e = '{data: 96'h7172737475767778797A7B7C, err: 1'b0, pops: 12, lat: 14};
    run_txn("post_rst", e);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
